// File: rtl/enigma_uart_letter_rx_if.sv
// rtl/enigma_uart_letter_rx_if.sv - letter stream handshake between UART front-end and Enigma core
// Purpose: carries one letter index per accepted transfer (out_valid && out_ready).
// Signals:
//   out_letter  5  letter index at the FIFO head (A/a=0 .. Z/z=25)
//   out_valid   1  producer has a letter
//   out_ready   1  consumer takes out_letter this cycle
// Modports: master = letter producer (receiver), slave = letter consumer (core).
interface enigma_uart_letter_rx_if;
  logic [4:0] out_letter;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_letter, output out_valid, input out_ready);
  modport slave  (input out_letter, input out_valid, output out_ready);
endinterface

// File: rtl/enigma_uart_letter_rx.sv
// rtl/enigma_uart_letter_rx.sv - 8N1 UART receiver keeping only ASCII letters, buffered in a FIFO
// Purpose: receives UART bytes on rxd, maps A-Z/a-z to 0-25, queues them for the Enigma core.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rxd          UART line, idle high, asynchronous to clk
//   out_if       letter stream (master): out_letter / out_valid / out_ready
//   busy         receiver FSM is not idle
//   framing_err  one-cycle pulse when the stop bit is sampled low
//   overflow     sticky: a letter was dropped because the FIFO was full
module enigma_uart_letter_rx #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rxd,
  enigma_uart_letter_rx_if.master   out_if,
  output logic                      busy,
  output logic                      framing_err,
  output logic                      overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Synchronizer and edge-detect history; all reset to the idle-high level.
  logic sync1_q, rxd_s_q, rxd_d_q;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          busy_q, ferr_q, ovf_q;

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;

  logic          is_upper_d, is_lower_d, is_letter_d;
  logic [4:0]    letter_d;
  logic          stop_tick_d, push_d, pop_d, empty_d, full_d;

  // shift_q holds the complete byte while in STOP, so classification reads it directly.
  assign is_upper_d  = (shift_q >= 8'h41) && (shift_q <= 8'h5A);
  assign is_lower_d  = (shift_q >= 8'h61) && (shift_q <= 8'h7A);
  assign is_letter_d = is_upper_d || is_lower_d;
  assign letter_d    = is_upper_d ? 5'(shift_q - 8'h41) : 5'(shift_q - 8'h61);

  assign stop_tick_d = (state_q == S_STOP) && (cnt_q == FULL_M1);
  assign push_d      = stop_tick_d && rxd_s_q && is_letter_d;

  assign empty_d = (wr_ptr_q == rd_ptr_q);
  assign full_d  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_d   = !empty_d && out_if.out_ready;

  assign out_if.out_valid  = !empty_d;
  assign out_if.out_letter = empty_d ? 5'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy        = busy_q;
  assign framing_err = ferr_q;
  assign overflow    = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
      rxd_d_q <= rxd_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Only a true high-to-low edge starts a frame; a line stuck low stays idle.
          if (rxd_d_q && !rxd_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (rxd_s_q) begin
              state_q <= S_IDLE;     // start bit vanished before mid-bit: glitch
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s_q, shift_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ferr_q  <= !rxd_s_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_d) begin
        if (!full_d || pop_d) begin
          mem_q[wr_ptr_q[AW-1:0]] <= letter_d;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (pop_d) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: doc/enigma_uart_letter_rx.md
# enigma_uart_letter_rx

Serial front-end that feeds the Enigma core. It receives 8N1 UART bytes on a single input pin and keeps only ASCII letters, mapping A–Z and a–z to a 5-bit letter index 0–25. Accepted letters are buffered in a small FIFO and presented to the downstream Enigma top through a valid/ready handshake, so a host terminal can stream plaintext without pacing to the core.

## Interface
- CLKS_PER_BIT, 1042: clock cycles per UART bit. Must be at least 4; it need not be even.
- FIFO_DEPTH, 4: letter FIFO entries. Must be a power of 2, at least 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- rxd  in  1  UART line, idle high, asynchronous to clk.
- out_letter  out  5  letter index at the FIFO head (A/a=0 … Z/z=25).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_letter this cycle.
- busy  out  1  receiver FSM is not in IDLE.
- framing_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overflow  out  1  sticky flag: a letter was dropped because the FIFO was full. Cleared only by reset.

## Operation
- rxd passes through a 2-flop synchronizer, whose flops reset to 1, giving rxd_s. A registered copy of rxd_s (rxd_d) is used for falling-edge detection.
- FSM states: IDLE, START, DATA, STOP. It has a bit-timing counter cnt (0..CLKS_PER_BIT-1) and a bit index idx (0..7).
  - IDLE: when rxd_d=1 and rxd_s=0, go to START with cnt=0. A line held low never re-triggers; it must return high first.
  - START: when cnt = CLKS_PER_BIT/2 − 1 (integer divide), sample rxd_s.
    - If the sample is 1, this is a glitch: go to IDLE with no other effect.
    - If the sample is 0, go to DATA with cnt=0 and idx=0.
  - DATA: when cnt = CLKS_PER_BIT−1, shift rxd_s into the shift register LSB-first and reset cnt. After idx=7, go to STOP with cnt=0.
  - STOP: when cnt = CLKS_PER_BIT−1, sample rxd_s and return to IDLE.
    - If the sample is 1, classify the byte.
    - If the sample is 0, pulse framing_err and discard the byte.
- Classification:
  - 0x41–0x5A maps to byte−0x41.
  - 0x61–0x7A maps to byte−0x61.
  - Every other byte is silently discarded, with no flag.
- FIFO:
  - Push happens on the STOP-sample edge for accepted letters. Pop happens when out_valid && out_ready.
  - Push while full with no pop in the same cycle: the letter is dropped, overflow is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed and occupancy stays at FIFO_DEPTH.
  - Push and pop in the same cycle while empty is impossible, because out_valid=0.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full is when the MSBs differ and the low bits are equal.
- out_letter is the head-entry read. It is 0 when the FIFO is empty and after reset, because storage resets to 0.
- Reset mid-frame aborts the frame and empties the FIFO. After reset is released, the receiver needs a fresh high→low transition to start.

## Timing
- Reset values:
  - out_valid=0, out_letter=0, busy=0, framing_err=0, overflow=0.
  - FSM in IDLE; cnt, idx and shift register all 0.
  - Synchronizer and rxd_d at 1.
- Start detection: the START state is entered 3 clk edges after the rxd falling edge (2 synchronizer edges plus 1 edge-detect edge). busy goes high in the same cycle.
- Sampling: the start bit is sampled mid-bit. Each data bit and the stop bit are sampled every CLKS_PER_BIT cycles after that, so all samples land near bit centers.
- Latency from the stop-sample edge: out_valid=1 and out_letter valid in the next cycle. busy=0 in that same cycle.
- framing_err is high for exactly the one cycle after the STOP-sample edge.
- Handshake: out_letter is stable while out_valid=1 and out_ready=0. After a pop, the next entry, if any, appears in the following cycle with no bubble.
- Back-to-back frames: IDLE can detect the next start edge in the first cycle after STOP.

## Test plan
- Send 'H' (0x48) at CLKS_PER_BIT=8 with out_ready=1 -> out_valid pulses for 1 cycle with out_letter=7. framing_err=0, overflow=0.
- Send 'a' then 'z' (0x61, 0x7A) with out_ready=0 -> out_valid=1 and out_letter=0. Raise out_ready -> 0, then 25, then out_valid=0.
- Send '1' (0x31) and '[' (0x5B) -> out_valid stays 0 and no flags are raised.
- Drive rxd low for CLKS_PER_BIT/2−2 cycles, then high -> busy pulses, then IDLE. No push, no framing_err.
- Send 0x41 with the stop bit forced low, hold rxd low for 3 bit-times, then send 'B' -> framing_err pulses once, nothing is pushed, then out_letter=1.
- Send 5 letters 'A'..'E' with out_ready=0 and FIFO_DEPTH=4 -> overflow=1. Pops return 0,1,2,3. Assert rst_n=0 mid-frame -> all outputs return to reset values immediately.
